// File: rtl/fp_add_normalize_round_if.sv
// Shared types and the lane bus for the floating-point add back end.
// The block drives the out_* half of the bus and consumes the in_* half.
package fp_add_pkg;
   typedef struct packed {
      logic [7:0] op;
      logic [5:0] dest_reg;
      logic       has_dest;
      logic       is_vector;
   } decoded_instruction_t;

   typedef logic [3:0] subcycle_t;
endpackage

interface fp_add_normalize_round_if #(
   parameter int LANES        = 16,
   parameter int THREAD_IDX_W = 2
);
   import fp_add_pkg::*;

   logic                          in_valid;
   decoded_instruction_t          in_instruction;
   logic [LANES-1:0]              in_mask;
   logic [THREAD_IDX_W-1:0]       in_thread_idx;
   subcycle_t                     in_subcycle;
   logic [LANES-1:0][27:0]        in_sum;
   logic [LANES-1:0][7:0]         in_exponent;
   logic [LANES-1:0]              in_result_sign;
   logic [LANES-1:0]              in_logical_subtract;

   logic                          out_valid;
   decoded_instruction_t          out_instruction;
   logic [LANES-1:0]              out_mask;
   logic [THREAD_IDX_W-1:0]       out_thread_idx;
   subcycle_t                     out_subcycle;
   logic [LANES-1:0][31:0]        out_result;

   modport master (
      output in_valid, in_instruction, in_mask, in_thread_idx, in_subcycle,
             in_sum, in_exponent, in_result_sign, in_logical_subtract,
      input  out_valid, out_instruction, out_mask, out_thread_idx, out_subcycle, out_result
   );

   modport slave (
      input  in_valid, in_instruction, in_mask, in_thread_idx, in_subcycle,
             in_sum, in_exponent, in_result_sign, in_logical_subtract,
      output out_valid, out_instruction, out_mask, out_thread_idx, out_subcycle, out_result
   );
endinterface

// File: rtl/fp_add_normalize_round.sv
// Post-add normalize (stage A) and round-to-nearest-even pack (stage B) for
// every lane, with instruction sideband and rollback squash riding alongside.
module fp_add_normalize_round #(
   parameter int LANES        = 16,
   parameter int THREAD_IDX_W = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wb_rollback_en,
   input  logic [THREAD_IDX_W-1:0] wb_rollback_thread_idx,
   fp_add_normalize_round_if.slave bus
);
   import fp_add_pkg::*;

   typedef struct packed {
      logic [23:0] sig;
      logic [8:0]  exp;
      logic        g;
      logic        r;
      logic        s;
      logic        sign;
      logic        zero;
      logic        lsub;
   } norm_t;

   // A zero biased exponent is treated as 1 so subnormals keep their scale
   // and a carry into bit 23 naturally becomes the smallest normal.
   function automatic norm_t normalize(input logic [27:0] sum, input logic [7:0] exp,
                                       input logic sign, input logic lsub);
      norm_t       n;
      logic [8:0]  e_eff;
      logic [4:0]  lz;
      logic [4:0]  sh;
      logic [25:0] x;
      n     = '0;
      e_eff = (exp == 8'd0) ? 9'd1 : {1'b0, exp};
      lz    = 5'd24;
      for (int i = 0; i < 24; i++) begin
         if (sum[3+i]) lz = 5'(23 - i);
      end
      if (sum[27]) begin
         sh    = 5'd0;
         x     = 26'd0;
         n.sig = sum[27:4];
         n.g   = sum[3];
         n.r   = sum[2];
         n.s   = sum[1] | sum[0];
         n.exp = e_eff + 9'd1;
      end else begin
         if ({4'd0, lz} < (e_eff - 9'd1)) sh = lz;
         else                              sh = 5'(e_eff - 9'd1);
         x     = sum[26:1] << sh;
         n.sig = x[25:2];
         n.g   = x[1];
         n.r   = x[0];
         n.s   = sum[0];
         n.exp = e_eff - {4'd0, sh};
      end
      n.sign = sign;
      n.zero = (sum == 28'd0);
      n.lsub = lsub;
      return n;
   endfunction

   function automatic logic [31:0] round_pack(input norm_t n);
      logic        up;
      logic [24:0] rs;
      logic [23:0] sig;
      logic [8:0]  e;
      logic [31:0] res;
      up = n.g & (n.r | n.s | n.sig[0]);
      rs = {1'b0, n.sig} + {24'd0, up};
      if (rs[24]) begin
         sig = 24'h800000;
         e   = n.exp + 9'd1;
      end else begin
         sig = rs[23:0];
         e   = n.exp;
      end
      if (n.zero)              res = n.lsub ? 32'd0 : {n.sign, 31'd0};
      else if (e >= 9'd255)    res = {n.sign, 8'hFF, 23'd0};
      else if (!sig[23])       res = {n.sign, 8'd0, sig[22:0]};
      else                     res = {n.sign, e[7:0], sig[22:0]};
      return res;
   endfunction

   logic                    a_valid_r;
   decoded_instruction_t    a_instruction_r;
   logic [LANES-1:0]        a_mask_r;
   logic [THREAD_IDX_W-1:0] a_thread_idx_r;
   subcycle_t               a_subcycle_r;
   norm_t                   a_lane_r [LANES];

   logic in_squash_s;
   logic a_squash_s;

   assign in_squash_s = wb_rollback_en & (wb_rollback_thread_idx == bus.in_thread_idx);
   assign a_squash_s  = wb_rollback_en & (wb_rollback_thread_idx == a_thread_idx_r);

   // Stage A: normalize every lane and capture sideband; valid drops on a matching rollback.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_valid_r       <= 1'b0;
         a_instruction_r <= '0;
         a_mask_r        <= '0;
         a_thread_idx_r  <= '0;
         a_subcycle_r    <= '0;
         for (int i = 0; i < LANES; i++) a_lane_r[i] <= '0;
      end else begin
         a_valid_r       <= bus.in_valid & ~in_squash_s;
         a_instruction_r <= bus.in_instruction;
         a_mask_r        <= bus.in_mask;
         a_thread_idx_r  <= bus.in_thread_idx;
         a_subcycle_r    <= bus.in_subcycle;
         for (int i = 0; i < LANES; i++) begin
            a_lane_r[i] <= normalize(bus.in_sum[i], bus.in_exponent[i],
                                     bus.in_result_sign[i], bus.in_logical_subtract[i]);
         end
      end
   end

   // Stage B: round and pack into the output registers; stage-A work for a rolled-back thread is dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.out_valid       <= 1'b0;
         bus.out_instruction <= '0;
         bus.out_mask        <= '0;
         bus.out_thread_idx  <= '0;
         bus.out_subcycle    <= '0;
         for (int i = 0; i < LANES; i++) bus.out_result[i] <= 32'd0;
      end else begin
         bus.out_valid       <= a_valid_r & ~a_squash_s;
         bus.out_instruction <= a_instruction_r;
         bus.out_mask        <= a_mask_r;
         bus.out_thread_idx  <= a_thread_idx_r;
         bus.out_subcycle    <= a_subcycle_r;
         for (int i = 0; i < LANES; i++) bus.out_result[i] <= round_pack(a_lane_r[i]);
      end
   end
endmodule

// File: tb/tb_fp_add_normalize_round.sv
// Directed bench for fp_add_normalize_round: packing, rounding, overflow,
// zero handling, sideband delay, rollback squash and asynchronous reset.
module tb_fp_add_normalize_round;
   import fp_add_pkg::*;

   localparam int LANES = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       wb_rollback_en;
   logic [1:0] wb_rollback_thread_idx;
   int         checks = 0;
   int         errors = 0;
   logic [31:0] exp_res [LANES];

   fp_add_normalize_round_if #(.LANES(LANES), .THREAD_IDX_W(2)) bus ();

   fp_add_normalize_round #(.LANES(LANES), .THREAD_IDX_W(2)) dut (
      .clk                    (clk),
      .reset                  (reset),
      .wb_rollback_en         (wb_rollback_en),
      .wb_rollback_thread_idx (wb_rollback_thread_idx),
      .bus                    (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.in_valid       = 1'b0;
      bus.in_instruction = '0;
      bus.in_mask        = '0;
      bus.in_thread_idx  = 2'd0;
      bus.in_subcycle    = '0;
      for (int i = 0; i < LANES; i++) begin
         bus.in_sum[i]              = 28'd0;
         bus.in_exponent[i]         = 8'd0;
         bus.in_result_sign[i]      = 1'b0;
         bus.in_logical_subtract[i] = 1'b0;
         exp_res[i]                 = 32'd0;
      end
   endtask

   task automatic set_lane(input int i, input logic [27:0] s, input logic [7:0] e,
                           input logic sg, input logic ls, input logic [31:0] r);
      bus.in_sum[i]              = s;
      bus.in_exponent[i]         = e;
      bus.in_result_sign[i]      = sg;
      bus.in_logical_subtract[i] = ls;
      exp_res[i]                 = r;
   endtask

   task automatic check_lanes(input string tag);
      for (int i = 0; i < LANES; i++) begin
         check($sformatf("%s_lane%0d", tag, i), bus.out_result[i], exp_res[i]);
      end
   endtask

   initial begin
      reset                  = 1'b0;
      wb_rollback_en         = 1'b0;
      wb_rollback_thread_idx = 2'd0;
      clear_inputs();
      #2 reset = 1'b1;
      #1;
      check("reset_valid", {31'd0, bus.out_valid}, 32'd0);
      check("reset_mask", {16'd0, bus.out_mask}, 32'd0);
      check_lanes("reset");
      tick();
      tick();
      reset = 1'b0;

      // Full vector of directed lane cases.
      set_lane(0,  28'h8000000, 8'd127, 1'b0, 1'b0, 32'h40000000);
      set_lane(1,  28'h4000004, 8'd127, 1'b0, 1'b0, 32'h3F800000);
      set_lane(2,  28'h400000C, 8'd127, 1'b0, 1'b0, 32'h3F800002);
      set_lane(3,  28'h2000000, 8'd127, 1'b0, 1'b1, 32'h3F000000);
      set_lane(4,  28'h0000000, 8'd127, 1'b1, 1'b1, 32'h00000000);
      set_lane(5,  28'h8000000, 8'd254, 1'b0, 1'b0, 32'h7F800000);
      set_lane(6,  28'h7FFFFFE, 8'd254, 1'b0, 1'b0, 32'h7F800000);
      set_lane(7,  28'h0000000, 8'd127, 1'b1, 1'b0, 32'h80000000);
      set_lane(8,  28'h4000000, 8'd128, 1'b1, 1'b0, 32'hC0000000);
      set_lane(9,  28'h0000008, 8'd0,   1'b0, 1'b0, 32'h00000001);
      set_lane(10, 28'h400001C, 8'd127, 1'b0, 1'b0, 32'h3F800004);
      set_lane(11, 28'h4000006, 8'd127, 1'b0, 1'b0, 32'h3F800001);
      bus.in_valid       = 1'b1;
      bus.in_thread_idx  = 2'd1;
      bus.in_mask        = 16'hA5A5;
      bus.in_subcycle    = 4'd3;
      bus.in_instruction = 16'h5A47;
      tick();
      bus.in_valid = 1'b0;
      check("lat1_valid", {31'd0, bus.out_valid}, 32'd0);
      tick();
      check("lat2_valid", {31'd0, bus.out_valid}, 32'd1);
      check("out_mask", {16'd0, bus.out_mask}, 32'h0000A5A5);
      check("out_thread", {30'd0, bus.out_thread_idx}, 32'd1);
      check("out_subcycle", {28'd0, bus.out_subcycle}, 32'd3);
      check("out_instr", {16'd0, bus.out_instruction}, 32'h00005A47);
      check_lanes("vec");
      tick();
      check("vec_done_valid", {31'd0, bus.out_valid}, 32'd0);

      // Back-to-back vectors.
      clear_inputs();
      set_lane(0, 28'h8000000, 8'd127, 1'b0, 1'b0, 32'h40000000);
      bus.in_valid = 1'b1;
      tick();
      set_lane(0, 28'h4000000, 8'd127, 1'b0, 1'b0, 32'h3F800000);
      tick();
      bus.in_valid = 1'b0;
      check("b2b_first_valid", {31'd0, bus.out_valid}, 32'd1);
      check("b2b_first_res", bus.out_result[0], 32'h40000000);
      tick();
      check("b2b_second_valid", {31'd0, bus.out_valid}, 32'd1);
      check("b2b_second_res", bus.out_result[0], 32'h3F800000);
      tick();
      check("b2b_idle_valid", {31'd0, bus.out_valid}, 32'd0);

      // Rollback of the in-flight thread one cycle after issue.
      bus.in_valid = 1'b1;
      bus.in_thread_idx = 2'd2;
      tick();
      bus.in_valid = 1'b0;
      wb_rollback_en = 1'b1;
      wb_rollback_thread_idx = 2'd2;
      tick();
      wb_rollback_en = 1'b0;
      check("rb_match_valid", {31'd0, bus.out_valid}, 32'd0);
      tick();
      check("rb_match_valid_later", {31'd0, bus.out_valid}, 32'd0);

      // Rollback of another thread leaves the work alone.
      bus.in_valid = 1'b1;
      bus.in_thread_idx = 2'd2;
      tick();
      bus.in_valid = 1'b0;
      wb_rollback_en = 1'b1;
      wb_rollback_thread_idx = 2'd1;
      tick();
      wb_rollback_en = 1'b0;
      check("rb_other_valid", {31'd0, bus.out_valid}, 32'd1);
      tick();

      // Rollback on the issue cycle, same thread then a different thread.
      bus.in_valid = 1'b1;
      bus.in_thread_idx = 2'd3;
      wb_rollback_en = 1'b1;
      wb_rollback_thread_idx = 2'd3;
      tick();
      bus.in_valid = 1'b0;
      wb_rollback_en = 1'b0;
      tick();
      check("rb_issue_same_valid", {31'd0, bus.out_valid}, 32'd0);
      bus.in_valid = 1'b1;
      wb_rollback_en = 1'b1;
      wb_rollback_thread_idx = 2'd0;
      tick();
      bus.in_valid = 1'b0;
      wb_rollback_en = 1'b0;
      tick();
      check("rb_issue_other_valid", {31'd0, bus.out_valid}, 32'd1);
      check("rb_issue_other_thread", {30'd0, bus.out_thread_idx}, 32'd3);

      // Reset with both stages occupied.
      clear_inputs();
      set_lane(0, 28'h8000000, 8'd127, 1'b0, 1'b0, 32'h40000000);
      bus.in_valid = 1'b1;
      bus.in_mask  = 16'h00FF;
      tick();
      tick();
      check("pre_reset_valid", {31'd0, bus.out_valid}, 32'd1);
      reset = 1'b1;
      #1;
      check("mid_reset_valid", {31'd0, bus.out_valid}, 32'd0);
      check("mid_reset_res", bus.out_result[0], 32'd0);
      check("mid_reset_mask", {16'd0, bus.out_mask}, 32'd0);
      bus.in_valid = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      check("post_reset_valid1", {31'd0, bus.out_valid}, 32'd0);
      tick();
      check("post_reset_valid2", {31'd0, bus.out_valid}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
